indicator_bar_driver: RTL and testbench
=======================================

# indicator_bar_driver

Consumer end of the indicator-position stream. Accepts 5-bit positions (0–31) over a valid/ready handshake and drives a 32-segment LED bar.
- Bar behaviour: instant attack, timed step-wise release.
- Peak dot: held for a fixed time, then falls toward the bar.
- Placement: sits between the PCM-to-position converter and the LED pins; all timing derives from an internal tick prescaler.

## Interface
- TICK_DIV, 1024: clk cycles per tick (≥2).
- HOLD_TICKS, 64: ticks the peak dot is held after a new peak (≥1).
- DECAY_TICKS, 4: ticks per one-segment fall of bar or peak (≥1).
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_valid  in  1  position valid.
- i_ready  out  1  block ready; a transfer occurs when i_valid && i_ready at a rising edge.
- i_position  in  5  position 0–31.
- o_bar  out  32  segment drive, bit k = segment k (bottom = 0).
- o_peak  out  5  current peak position.

## Operation
- Registers:
  - target: last accepted position.
  - level: bar height, 0–31.
  - peak: 0–31.
  - pk_state: REST / HOLD / FALL.
  - tick_cnt, decay_cnt, hold_cnt.
- Tick: tick_cnt counts 0..TICK_DIV-1 and wraps. tick=1 for one cycle when tick_cnt==TICK_DIV-1.
- Step: decay_cnt advances on each tick and wraps at DECAY_TICKS-1. step=1 when tick && decay_cnt==DECAY_TICKS-1.
- Prescaler free-runs. Samples never reset tick_cnt or decay_cnt.
- Accept of p:
  - target←p.
  - If p ≥ level: level←p.
- Bar release: on step with no accept in that cycle, if level > target then level←level-1.
- Peak on accept of p with p>0 and p ≥ peak: peak←p, hold_cnt←HOLD_TICKS, pk_state←HOLD.
- Peak otherwise, per state:
  - REST: peak←new level, every cycle.
  - HOLD: on tick, hold_cnt−1. When a tick occurs with hold_cnt==1 → FALL.
  - FALL: on step, if peak-1 ≤ level then peak←level and pk_state←REST; else peak←peak-1.
- Segment map: o_bar[k] = (k < level) | (k == peak && peak != 0).
  - Position 0 gives a dark bar.
  - Position 31 with peak 31 lights all 32 segments.
- Simultaneous events:
  - Accept and step in the same cycle: the accept wins, and that step is dropped for both level and peak.
  - Prescaler counters still advance.
- Invariant: peak ≥ level at all times.
- Arithmetic:
  - Positions are unsigned 5-bit; no wrap below 0.
  - Counter widths are $clog2 of the respective parameter + 1.

## Timing
- i_ready:
  - 0 while reset is low.
  - 1 from the first rising edge after reset release, permanently.
  - No backpressure; one sample can be accepted per cycle.
- Latency: an accept at edge N is visible on o_bar/o_peak after edge N (outputs are registered, from next-state logic).
- Reset values (async, immediate):
  - o_bar=0, o_peak=0, i_ready=0.
  - level=target=peak=0, pk_state=REST, all counters 0.
- Reset asserted mid-operation: all state clears within the same cycle; no residual hold or decay.
- i_position is ignored when i_valid=0 or i_ready=0.

## Structure
- Package indicator_pkg holds:
  - POS_W=5 and SEGMENTS=32.
  - The pk_state enum (REST, HOLD, FALL).
  - These are shared with pcm_to_position-side blocks.
- Sub-module tick_prescaler (parameter DIV; ports clk, reset, o_tick) generates tick.
- Step, hold and bar logic stay in indicator_bar_driver.

## Test plan
Bench parameters: TICK_DIV=4, HOLD_TICKS=3, DECAY_TICKS=2, so one step every 8 cycles.
- Reset: hold reset low 5 cycles, then release → o_bar=0, o_peak=0, i_ready=0 during reset; i_ready=1 one edge after release.
- Attack: send 20 → next cycle o_bar=0x001F_FFFF, o_peak=20, pk_state HOLD.
- Release: send 20, then 5 →
  - level falls by 1 every 8 cycles, reaching 5 after 15 steps.
  - peak stays 20 for 3 ticks, then falls 1 per step until it equals level, then enters REST.
  - Final o_bar=0x0000_003F.
- Full scale: send 31 → o_bar=0xFFFF_FFFF, o_peak=31; then 0 → bar and peak eventually 0, o_bar=0.
- Collision: schedule an accept of 10 on the exact cycle step fires, with level=12 and target=10 → level stays 12 that cycle and decrements only on the next step.
- Mid-reset: during FALL with peak=18, level=7, pulse reset low for 1 cycle → all outputs 0 immediately; the next accept of 3 gives o_bar=0x0000_000F.

Source files
------------

// File: rtl/indicator_pkg.sv
// Shared definitions for the indicator-position stream blocks.
package indicator_pkg;

  localparam int unsigned POS_W    = 5;
  localparam int unsigned SEGMENTS = 32;

  typedef enum logic [1:0] {
    REST = 2'd0,
    HOLD = 2'd1,
    FALL = 2'd2
  } pk_state_e;

  // Segment k lights when it lies below the bar or is the (non-zero) peak dot.
  function automatic logic [SEGMENTS-1:0] bar_map(input logic [POS_W-1:0] level,
                                                  input logic [POS_W-1:0] peak);
    logic [SEGMENTS-1:0] seg;
    for (int k = 0; k < SEGMENTS; k++) begin
      seg[k] = (k < int'(level)) || ((k == int'(peak)) && (peak != '0));
    end
    return seg;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: one-cycle tick every DIV clock cycles.
module tick_prescaler #(
  parameter int unsigned DIV = 1024
) (
  input  logic clk,
  input  logic reset,
  output logic o_tick
);

  localparam int unsigned CW = $clog2(DIV) + 1;
  localparam logic [CW-1:0] CntLast = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  // Tick is decoded from the count so it lines up with the wrap cycle.
  always_comb begin
    o_tick = (cnt_q == CntLast);
  end

  // Count 0..DIV-1 and wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (o_tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/indicator_bar_driver.sv
// LED bar driver: instant attack, step-wise release, held-then-falling peak dot.
module indicator_bar_driver
  import indicator_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 1024,
  parameter int unsigned HOLD_TICKS  = 64,
  parameter int unsigned DECAY_TICKS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_valid,
  output logic                i_ready,
  input  logic [POS_W-1:0]    i_position,
  output logic [SEGMENTS-1:0] o_bar,
  output logic [POS_W-1:0]    o_peak
);

  localparam int unsigned DW = $clog2(DECAY_TICKS) + 1;
  localparam int unsigned HW = $clog2(HOLD_TICKS) + 1;
  localparam logic [DW-1:0] DecayLast = DW'(DECAY_TICKS - 1);
  localparam logic [HW-1:0] HoldInit  = HW'(HOLD_TICKS);

  logic                tick;
  logic                step;
  logic                accept;
  logic                ready_q;
  logic [DW-1:0]       decay_q, decay_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [POS_W-1:0]    target_q, target_d;
  logic [POS_W-1:0]    level_q, level_d;
  logic [POS_W-1:0]    peak_q, peak_d;
  pk_state_e           state_q, state_d;
  logic [SEGMENTS-1:0] bar_q, bar_d;

  tick_prescaler #(
    .DIV (TICK_DIV)
  ) u_tick_prescaler (
    .clk    (clk),
    .reset  (reset),
    .o_tick (tick)
  );

  assign accept = i_valid && ready_q;
  assign step   = tick && (decay_q == DecayLast);

  // State register: everything clears asynchronously, ready rises on the first edge after.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_q  <= 1'b0;
      decay_q  <= '0;
      hold_q   <= '0;
      target_q <= '0;
      level_q  <= '0;
      peak_q   <= '0;
      state_q  <= REST;
      bar_q    <= '0;
    end else begin
      ready_q  <= 1'b1;
      decay_q  <= decay_d;
      hold_q   <= hold_d;
      target_q <= target_d;
      level_q  <= level_d;
      peak_q   <= peak_d;
      state_q  <= state_d;
      bar_q    <= bar_d;
    end
  end

  // Next-state: step divider, bar attack/release and the peak-dot FSM.
  always_comb begin
    decay_d  = decay_q;
    target_d = target_q;
    level_d  = level_q;
    state_d  = state_q;
    peak_d   = peak_q;
    hold_d   = hold_q;

    if (tick) begin
      decay_d = (decay_q == DecayLast) ? '0 : decay_q + DW'(1);
    end

    // An accept in a step cycle swallows that step.
    if (accept) begin
      target_d = i_position;
      if (i_position >= level_q) begin
        level_d = i_position;
      end
    end else if (step && (level_q > target_q)) begin
      level_d = level_q - POS_W'(1);
    end

    if (accept && (i_position != '0) && (i_position >= peak_q)) begin
      peak_d  = i_position;
      hold_d  = HoldInit;
      state_d = HOLD;
    end else begin
      unique case (state_q)
        REST: peak_d = level_d;
        HOLD: begin
          if (tick) begin
            hold_d = hold_q - HW'(1);
            if (hold_q == HW'(1)) begin
              state_d = FALL;
            end
          end
        end
        FALL: begin
          if (step && !accept) begin
            // Zero guard keeps peak-1 from wrapping.
            if ((peak_q == '0) || ((peak_q - POS_W'(1)) <= level_d)) begin
              peak_d  = level_d;
              state_d = REST;
            end else begin
              peak_d = peak_q - POS_W'(1);
            end
          end
        end
        default: state_d = REST;
      endcase
    end
  end

  // Outputs: segment image computed from next-state so it is registered with it.
  always_comb begin
    bar_d   = bar_map(level_d, peak_d);
    o_bar   = bar_q;
    o_peak  = peak_q;
    i_ready = ready_q;
  end

endmodule

// File: tb/tb_indicator_bar_driver.sv
// Randomized and directed bench for indicator_bar_driver against a cycle-level model.
module tb_indicator_bar_driver;

  localparam int TD = 4;  // TICK_DIV
  localparam int HT = 3;  // HOLD_TICKS
  localparam int DT = 2;  // DECAY_TICKS

  localparam int Resting = 0;
  localparam int Holding = 1;
  localparam int Falling = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid;
  logic        i_ready;
  logic [4:0]  i_position;
  logic [31:0] o_bar;
  logic [4:0]  o_peak;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, in plain integers.
  int m_e;
  int m_level;
  int m_target;
  int m_peak;
  int m_hold_left;
  int m_mode;
  bit m_ready;

  indicator_bar_driver #(
    .TICK_DIV    (TD),
    .HOLD_TICKS  (HT),
    .DECAY_TICKS (DT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_valid    (i_valid),
    .i_ready    (i_ready),
    .i_position (i_position),
    .o_bar      (o_bar),
    .o_peak     (o_peak)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_bar();
    logic [63:0] m;
    m = (64'd1 << m_level) - 64'd1;
    if (m_peak != 0) m = m | (64'd1 << m_peak);
    return m[31:0];
  endfunction

  task automatic model_reset();
    m_e = 0; m_level = 0; m_target = 0; m_peak = 0;
    m_hold_left = 0; m_mode = Resting; m_ready = 1'b0;
  endtask

  // One rising edge of the reference behaviour; m_e counts edges since reset release.
  task automatic model_edge(input bit v, input int p);
    bit acc, tk, st;
    int nl;
    acc = v && m_ready;
    tk  = (m_e % TD) == TD - 1;
    st  = tk && (((m_e / TD) % DT) == DT - 1);
    nl  = m_level;
    if (acc) begin
      m_target = p;
      if (p >= m_level) nl = p;
    end else if (st && m_level > m_target) begin
      nl = m_level - 1;
    end
    if (acc && p > 0 && p >= m_peak) begin
      m_peak = p; m_hold_left = HT; m_mode = Holding;
    end else if (m_mode == Resting) begin
      m_peak = nl;
    end else if (m_mode == Holding) begin
      if (tk) begin
        m_hold_left--;
        if (m_hold_left == 0) m_mode = Falling;
      end
    end else if (st && !acc) begin
      if (m_peak - 1 <= nl) begin
        m_peak = nl; m_mode = Resting;
      end else begin
        m_peak--;
      end
    end
    m_level = nl;
    m_ready = 1'b1;
    m_e++;
  endtask

  // Drive inputs, take one edge, then compare all outputs with the model.
  task automatic cycle(input bit v, input int p);
    i_valid    = v;
    i_position = 5'(p);
    @(posedge clk);
    model_edge(v, p);
    #1;
    check_eq("bar", o_bar, exp_bar());
    check_eq("peak", 32'(o_peak), 32'(m_peak));
    check_eq("ready", 32'(i_ready), 32'(m_ready));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, $urandom_range(0, 31));
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    check_eq("rst_bar", o_bar, 32'h0);
    check_eq("rst_peak", 32'(o_peak), 32'h0);
    check_eq("rst_ready", 32'(i_ready), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    i_valid    = 1'b0;
    i_position = '0;
    reset      = 1'b1;
    model_reset();
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_eq("reset_bar", o_bar, 32'h0);
    check_eq("reset_peak", 32'(o_peak), 32'h0);
    check_eq("reset_ready", 32'(i_ready), 32'h0);
    reset = 1'b1;
    model_reset();

    cycle(1'b0, 0);
    check_eq("ready_after_release", 32'(i_ready), 32'h1);

    // Attack
    cycle(1'b1, 20);
    check_eq("attack_bar", o_bar, 32'h001F_FFFF);
    check_eq("attack_peak", 32'(o_peak), 32'd20);

    // Release toward 5
    cycle(1'b1, 20);
    cycle(1'b1, 5);
    idle(6);
    check_eq("release_peak_held", 32'(o_peak), 32'd20);
    idle(160);
    check_eq("release_bar", o_bar, 32'h0000_003F);
    check_eq("release_peak", 32'(o_peak), 32'd5);

    // Full scale and back to dark
    cycle(1'b1, 31);
    check_eq("full_bar", o_bar, 32'hFFFF_FFFF);
    check_eq("full_peak", 32'(o_peak), 32'd31);
    cycle(1'b1, 0);
    idle(300);
    check_eq("dark_bar", o_bar, 32'h0);
    check_eq("dark_peak", 32'(o_peak), 32'h0);

    // Collision: accept of 10 lands on the step edge with level 12, target 10
    for (int i = 0; i < 8 && (m_e % 8) != 5; i++) cycle(1'b0, 0);
    cycle(1'b1, 12);
    cycle(1'b1, 10);
    cycle(1'b1, 10);
    check_eq("collide_bar", o_bar, 32'h0000_1FFF);
    idle(7);
    check_eq("collide_hold_bar", o_bar, 32'h0000_1FFF);
    cycle(1'b0, 0);
    check_eq("collide_next_step_bar", o_bar, 32'h0000_17FF);

    // Mid-operation reset while the peak is falling
    pulse_reset();
    cycle(1'b0, 0);
    cycle(1'b1, 3);
    check_eq("post_reset_bar", o_bar, 32'h0000_000F);
    check_eq("post_reset_peak", 32'(o_peak), 32'd3);

    // Random traffic with occasional bursts, long idles and resets
    for (int blk = 0; blk < 3; blk++) begin
      for (int i = 0; i < 1200; i++) begin
        int r;
        int p;
        r = int'($urandom_range(0, 99));
        p = (r < 10) ? 31 : (r < 20) ? 0 : int'($urandom_range(0, 31));
        if (r < 30) cycle(1'b1, p);
        else if (r < 33) idle(int'($urandom_range(10, 60)));
        else cycle(1'b0, p);
      end
      pulse_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
